// File: rtl/bubble_buffer_reader_pkg.sv
// ----------------------------------------------------------------------------
// bubble_buffer_reader_pkg
// Shared definitions for the bubble output-buffer reader:
//   - FSM state encoding
//   - ACCTYPE bit positions
//   - default START / WORDS values for the bootloader and page regions
//   - RAM word address width
// ----------------------------------------------------------------------------
package bubble_buffer_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // ACCTYPE[1] = read active, ACCTYPE[0] = 1 page / 0 bootloader
    localparam int ACC_RD_BIT = 1;
    localparam int ACC_PG_BIT = 0;

    localparam int ADDR_W = 14;

    localparam logic [12:0] DEF_BOOT_START = 13'd2053;
    localparam logic [12:0] DEF_BOOT_WORDS = 13'd1928;   // (2656 + 1200) / 2
    localparam logic [12:0] DEF_PAGE_START = 13'd7168;
    localparam logic [12:0] DEF_PAGE_WORDS = 13'd584;    // includes bad-loop padding

endpackage

// File: rtl/bubble_buffer_reader_ram.sv
// ----------------------------------------------------------------------------
// bubble_buffer_ram
// 16K x 2-bit simple dual-port RAM holding the two bubble channels.
// Ports:
//   clk        : clock
//   i_wr_en    : write enable (one bit per write)
//   i_wr_addr  : write word address
//   i_wr_sel   : bit (channel) selected for the write
//   i_wr_data  : write bit
//   i_rd_en    : read enable
//   i_rd_addr  : read word address
//   o_rd_data  : registered 2-bit read data (bit 0 = channel 0)
// A same-cycle read and write of one word returns the old contents.
// ----------------------------------------------------------------------------
module bubble_buffer_ram
    import bubble_buffer_reader_pkg::*;
(
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic              i_wr_sel,
    input  logic              i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [1:0]        o_rd_data
);

    logic [1:0] r_mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr][i_wr_sel] <= i_wr_data;
        end
        if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule

// File: rtl/bubble_buffer_reader.sv
// ----------------------------------------------------------------------------
// bubble_buffer_reader
// Streams bootloader or page words from the output buffer RAM onto the two
// bubble data lines, one word per nBITSTRB pulse.
// Ports:
//   MCLK           : 48 MHz clock
//   nRESET         : asynchronous active-low reset
//   nOUTBUFWRCLKEN : loader write strobe, active-low
//   OUTBUFWRADDR   : loader bit address ([0] channel, [14:1] word)
//   OUTBUFWRDATA   : loader write bit
//   ACCTYPE        : [1] read active, [0] page(1)/bootloader(0)
//   nBITSTRB       : one-MCLK low pulse per bubble bit period
//   DOUT0 / DOUT1  : channel 0 / channel 1 data
//   nBUSY          : low while a transfer is in progress
//   nOVERRUN       : sticky overrun flag, active-low
// Optional feature: define BUBBLE_BUF_OVERRUN_CHK_EN to build the overrun
// detector (strobe seen after the transfer completed).
// ----------------------------------------------------------------------------
module bubble_buffer_reader
    import bubble_buffer_reader_pkg::*;
#(
    parameter logic [12:0] BOOT_START = DEF_BOOT_START,
    parameter logic [12:0] BOOT_WORDS = DEF_BOOT_WORDS,
    parameter logic [12:0] PAGE_START = DEF_PAGE_START,
    parameter logic [12:0] PAGE_WORDS = DEF_PAGE_WORDS
)(
    input  logic        MCLK,
    input  logic        nRESET,
    input  logic        nOUTBUFWRCLKEN,
    input  logic [14:0] OUTBUFWRADDR,
    input  logic        OUTBUFWRDATA,
    input  logic [2:0]  ACCTYPE,
    input  logic        nBITSTRB,
    output logic        DOUT0,
    output logic        DOUT1,
    output logic        nBUSY,
    output logic        nOVERRUN
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_word_addr;
    logic [12:0]       r_word_cnt;
    logic              r_pg_sel;
    logic              r_vld_p0, r_vld_p1;
    logic              r_zero_p0, r_zero_p1;
    logic [1:0]        r_data_p1;

    logic [1:0]        w_rd_data;
    logic              w_rd_act;
    logic              w_strobe;
    logic              w_rd_en;
    logic [12:0]       w_words;
    logic [12:0]       w_cnt_nxt;
    logic              w_unused;

    assign w_rd_act  = ACCTYPE[ACC_RD_BIT];
    // A strobe coinciding with the read-active drop is dropped with the access.
    assign w_strobe  = ~nBITSTRB & w_rd_act;
    assign w_rd_en   = (r_state == ST_RUN) & w_strobe;
    assign w_words   = r_pg_sel ? PAGE_WORDS : BOOT_WORDS;
    assign w_cnt_nxt = r_word_cnt + 13'd1;
    assign w_unused  = ACCTYPE[2];

    bubble_buffer_ram u_ram (
        .clk       (MCLK),
        .i_wr_en   (~nOUTBUFWRCLKEN),
        .i_wr_addr (OUTBUFWRADDR[14:1]),
        .i_wr_sel  (OUTBUFWRADDR[0]),
        .i_wr_data (OUTBUFWRDATA),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_word_addr),
        .o_rd_data (w_rd_data)
    );

    // Stage p1: read data capture (data path, not reset)
    always_ff @(posedge MCLK) begin
        r_data_p1 <= w_rd_data;
    end

    // FSM, address/count, valid pipeline and registered outputs
    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            r_state     <= ST_IDLE;
            r_word_addr <= '0;
            r_word_cnt  <= '0;
            r_pg_sel    <= 1'b0;
            r_vld_p0    <= 1'b0;
            r_vld_p1    <= 1'b0;
            r_zero_p0   <= 1'b0;
            r_zero_p1   <= 1'b0;
            DOUT0       <= 1'b0;
            DOUT1       <= 1'b0;
            nBUSY       <= 1'b1;
        end else begin
            r_vld_p0  <= 1'b0;
            r_zero_p0 <= 1'b0;
            r_vld_p1  <= r_vld_p0;
            r_zero_p1 <= r_zero_p0;

            // Output stage: two cycles after the strobe (or after DONE entry)
            if (r_vld_p1) begin
                DOUT0 <= r_data_p1[0];
                DOUT1 <= r_data_p1[1];
            end
            if (r_zero_p1) begin
                DOUT0 <= 1'b0;
                DOUT1 <= 1'b0;
                nBUSY <= 1'b1;
            end

            if (!w_rd_act) begin
                // Abort: flush anything in flight and return to idle outputs
                r_state   <= ST_IDLE;
                r_vld_p0  <= 1'b0;
                r_vld_p1  <= 1'b0;
                r_zero_p0 <= 1'b0;
                r_zero_p1 <= 1'b0;
                DOUT0     <= 1'b0;
                DOUT1     <= 1'b0;
                nBUSY     <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state     <= ST_LOAD;
                        r_pg_sel    <= ACCTYPE[ACC_PG_BIT];
                        r_word_addr <= ACCTYPE[ACC_PG_BIT] ? {1'b0, PAGE_START}
                                                           : {1'b0, BOOT_START};
                        r_word_cnt  <= '0;
                        nBUSY       <= 1'b0;
                    end
                    ST_LOAD: begin
                        r_state <= ST_RUN;
                    end
                    ST_RUN: begin
                        if (w_strobe) begin
                            r_vld_p0    <= 1'b1;
                            r_word_addr <= r_word_addr + 1'b1;
                            r_word_cnt  <= w_cnt_nxt;
                            if (w_cnt_nxt == w_words) begin
                                r_state <= ST_DONE;
                            end
                        end
                    end
                    ST_DONE: begin
                        r_zero_p0 <= 1'b1;
                    end
                endcase
            end
        end
    end

`ifdef BUBBLE_BUF_OVERRUN_CHK_EN
    logic r_novr;

    // Sticky until reset or the start of the next transfer
    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            r_novr <= 1'b1;
        end else if (r_state == ST_IDLE && w_rd_act) begin
            r_novr <= 1'b1;
        end else if (r_state == ST_DONE && w_strobe) begin
            r_novr <= 1'b0;
        end
    end

    assign nOVERRUN = r_novr;
`else
    assign nOVERRUN = 1'b1;
`endif

endmodule

// File: tb/tb_bubble_buffer_reader.sv
module tb_bubble_buffer_reader;

    localparam int BOOT_START = 2053;
    localparam int PAGE_START = 7168;
    localparam int PAGE_WORDS = 584;

    logic        MCLK = 1'b0;
    logic        nRESET = 1'b0;
    logic        nOUTBUFWRCLKEN = 1'b1;
    logic [14:0] OUTBUFWRADDR = '0;
    logic        OUTBUFWRDATA = 1'b0;
    logic [2:0]  ACCTYPE = 3'b000;
    logic        nBITSTRB = 1'b1;
    logic        DOUT0, DOUT1, nBUSY, nOVERRUN;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference image of the buffer as the loader has written it
    logic [1:0] mdl [0:16383];

    bubble_buffer_reader dut (
        .MCLK           (MCLK),
        .nRESET         (nRESET),
        .nOUTBUFWRCLKEN (nOUTBUFWRCLKEN),
        .OUTBUFWRADDR   (OUTBUFWRADDR),
        .OUTBUFWRDATA   (OUTBUFWRDATA),
        .ACCTYPE        (ACCTYPE),
        .nBITSTRB       (nBITSTRB),
        .DOUT0          (DOUT0),
        .DOUT1          (DOUT1),
        .nBUSY          (nBUSY),
        .nOVERRUN       (nOVERRUN)
    );

    always #5 MCLK = ~MCLK;

    task automatic cyc();
        @(negedge MCLK);
    endtask

    task automatic wr_bit(input int word, input int ch, input logic b);
        OUTBUFWRADDR   = 15'(word * 2 + ch);
        OUTBUFWRDATA   = b;
        nOUTBUFWRCLKEN = 1'b0;
        cyc();
        nOUTBUFWRCLKEN = 1'b1;
        mdl[word][ch]  = b;
    endtask

    task automatic wr_word(input int word, input logic [1:0] v);
        wr_bit(word, 0, v[0]);
        wr_bit(word, 1, v[1]);
    endtask

    // One strobe; returns outputs one and two cycles after the strobe edge
    task automatic strobe(input int gap, output logic [1:0] mid, output logic [1:0] fin);
        nBITSTRB = 1'b0;
        cyc();
        nBITSTRB = 1'b1;
        cyc();
        mid = {DOUT1, DOUT0};
        cyc();
        fin = {DOUT1, DOUT0};
        repeat (gap) cyc();
    endtask

    task automatic start(input logic pg);
        ACCTYPE = {1'b0, 1'b1, pg};
        repeat (3) cyc();
    endtask

    task automatic stop();
        ACCTYPE = 3'b000;
        repeat (2) cyc();
    endtask

    task automatic test_reset();
        nRESET = 1'b0;
        repeat (2) cyc();
        n_tests++; if (DOUT0 !== 1'b0) begin n_fail++; $display("FAIL reset_dout0: got %b want 0", DOUT0); end
        n_tests++; if (DOUT1 !== 1'b0) begin n_fail++; $display("FAIL reset_dout1: got %b want 0", DOUT1); end
        n_tests++; if (nBUSY !== 1'b1) begin n_fail++; $display("FAIL reset_nbusy: got %b want 1", nBUSY); end
        n_tests++; if (nOVERRUN !== 1'b1) begin n_fail++; $display("FAIL reset_novr: got %b want 1", nOVERRUN); end
        nRESET = 1'b1;
        repeat (2) cyc();
    endtask

    task automatic test_boot_read();
        logic [1:0] mid, fin, prev;
        wr_word(BOOT_START,     2'b01);
        wr_word(BOOT_START + 1, 2'b10);
        start(1'b0);
        n_tests++; if (nBUSY !== 1'b0) begin n_fail++; $display("FAIL boot_busy: got %b want 0", nBUSY); end
        prev = 2'b00;
        for (int i = 0; i < 2; i++) begin
            strobe($urandom_range(2, 0), mid, fin);
            n_tests++; if (mid !== prev) begin n_fail++; $display("FAIL boot_hold[%0d]: got %b want %b", i, mid, prev); end
            n_tests++; if (fin !== mdl[BOOT_START + i]) begin n_fail++; $display("FAIL boot_data[%0d]: got %b want %b", i, fin, mdl[BOOT_START + i]); end
            prev = mdl[BOOT_START + i];
        end
        stop();
        n_tests++; if ({DOUT1, DOUT0, nBUSY} !== 3'b001) begin n_fail++; $display("FAIL boot_stop: got %b want 001", {DOUT1, DOUT0, nBUSY}); end
    endtask

    task automatic test_page_collision();
        logic [1:0] mid, fin, prev, exp;
        logic       exp_novr;
        for (int w = 0; w < PAGE_WORDS; w++) begin
            logic [1:0] v;
            v = 2'($urandom_range(3, 0));
            if (w == 0) v[0] = 1'b0;
            wr_word(PAGE_START + w, v);
        end
        start(1'b1);
        // First strobe collides with a write of 1 to channel 0 of the first word
        exp            = mdl[PAGE_START];
        OUTBUFWRADDR   = 15'(PAGE_START * 2);
        OUTBUFWRDATA   = 1'b1;
        nOUTBUFWRCLKEN = 1'b0;
        nBITSTRB       = 1'b0;
        cyc();
        nOUTBUFWRCLKEN = 1'b1;
        nBITSTRB       = 1'b1;
        mdl[PAGE_START][0] = 1'b1;
        cyc();
        cyc();
        fin = {DOUT1, DOUT0};
        n_tests++; if (fin !== exp) begin n_fail++; $display("FAIL collide_old: got %b want %b", fin, exp); end
        prev = exp;
        for (int i = 1; i < PAGE_WORDS; i++) begin
            strobe($urandom_range(2, 0), mid, fin);
            n_tests++; if (mid !== prev) begin n_fail++; $display("FAIL page_hold[%0d]: got %b want %b", i, mid, prev); end
            n_tests++; if (fin !== mdl[PAGE_START + i]) begin n_fail++; $display("FAIL page_data[%0d]: got %b want %b", i, fin, mdl[PAGE_START + i]); end
            prev = mdl[PAGE_START + i];
            if (i == 300) begin
                n_tests++; if (nBUSY !== 1'b0) begin n_fail++; $display("FAIL page_busy: got %b want 0", nBUSY); end
            end
        end
        repeat (3) cyc();
        n_tests++; if ({DOUT1, DOUT0, nBUSY} !== 3'b001) begin n_fail++; $display("FAIL page_done: got %b want 001", {DOUT1, DOUT0, nBUSY}); end
        // Strobe after completion
`ifdef BUBBLE_BUF_OVERRUN_CHK_EN
        exp_novr = 1'b0;
`else
        exp_novr = 1'b1;
`endif
        nBITSTRB = 1'b0;
        cyc();
        nBITSTRB = 1'b1;
        n_tests++; if (nOVERRUN !== exp_novr) begin n_fail++; $display("FAIL overrun: got %b want %b", nOVERRUN, exp_novr); end
        cyc();
        cyc();
        n_tests++; if ({DOUT1, DOUT0} !== 2'b00) begin n_fail++; $display("FAIL done_strobe: got %b want 00", {DOUT1, DOUT0}); end
        stop();
        start(1'b1);
        n_tests++; if (nOVERRUN !== 1'b1) begin n_fail++; $display("FAIL overrun_clear: got %b want 1", nOVERRUN); end
        strobe(0, mid, fin);
        n_tests++; if (fin[0] !== 1'b1) begin n_fail++; $display("FAIL collide_reread: got %b want 1", fin[0]); end
        stop();
    endtask

    task automatic test_abort_restart();
        logic [1:0] mid, fin, prev;
        for (int w = 2; w < 99; w++) wr_word(BOOT_START + w, 2'($urandom_range(3, 0)));
        wr_word(BOOT_START + 99, 2'b11);
        start(1'b0);
        prev = 2'b00;
        for (int i = 0; i < 99; i++) begin
            strobe($urandom_range(2, 0), mid, fin);
            n_tests++; if (fin !== mdl[BOOT_START + i]) begin n_fail++; $display("FAIL abort_data[%0d]: got %b want %b", i, fin, mdl[BOOT_START + i]); end
            prev = fin;
        end
        // 100th strobe, then read-active drops with another strobe in the same cycle
        nBITSTRB = 1'b0;
        cyc();
        ACCTYPE = 3'b000;
        cyc();
        nBITSTRB = 1'b1;
        n_tests++; if ({DOUT1, DOUT0, nBUSY} !== 3'b001) begin n_fail++; $display("FAIL abort_out: got %b want 001", {DOUT1, DOUT0, nBUSY}); end
        cyc();
        n_tests++; if ({DOUT1, DOUT0} !== 2'b00) begin n_fail++; $display("FAIL abort_inflight: got %b want 00", {DOUT1, DOUT0}); end
        for (int i = 0; i < 3; i++) begin
            strobe(0, mid, fin);
            n_tests++; if (fin !== 2'b00) begin n_fail++; $display("FAIL idle_strobe[%0d]: got %b want 00", i, fin); end
        end
        start(1'b0);
        strobe(0, mid, fin);
        n_tests++; if (fin !== mdl[BOOT_START]) begin n_fail++; $display("FAIL restart: got %b want %b", fin, mdl[BOOT_START]); end
        stop();
    endtask

    task automatic test_async_reset();
        logic [1:0] mid, fin;
        start(1'b1);
        strobe(0, mid, fin);
        n_tests++; if (fin !== mdl[PAGE_START]) begin n_fail++; $display("FAIL ares_pre: got %b want %b", fin, mdl[PAGE_START]); end
        #2 nRESET = 1'b0;
        #1;
        n_tests++; if ({DOUT1, DOUT0, nBUSY, nOVERRUN} !== 4'b0011) begin n_fail++; $display("FAIL ares_out: got %b want 0011", {DOUT1, DOUT0, nBUSY, nOVERRUN}); end
        cyc();
        nRESET = 1'b1;
        repeat (3) cyc();
        strobe(0, mid, fin);
        n_tests++; if (mid !== 2'b00) begin n_fail++; $display("FAIL ares_hold: got %b want 00", mid); end
        n_tests++; if (fin !== mdl[PAGE_START]) begin n_fail++; $display("FAIL ares_restart: got %b want %b", fin, mdl[PAGE_START]); end
        stop();
    endtask

    initial begin
        test_reset();
        test_boot_read();
        test_page_collision();
        test_abort_restart();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
